// File: rtl/cpu_boot_mem.sv
// cpu_boot_mem: unified CPU memory with a length-prefixed byte-stream boot loader.
// Define CPU_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte before the CPU is released.
module cpu_boot_mem #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              load_done,
    output logic              load_err
);
    localparam int DEPTH = 1 << ADDR_W;
    typedef enum logic [2:0] {
        HDR_HI, HDR_LO, DAT_HI, DAT_LO, RUN, ERR
`ifdef CPU_BOOT_CHECKSUM_EN
        , CHK
`endif
    } state_t;
`ifdef CPU_BOOT_CHECKSUM_EN
    localparam state_t DONE = CHK;
`else
    localparam state_t DONE = RUN;
`endif
    state_t state_q, state_d;
    logic [15:0] len_q, len_d, idx_q, idx_d;
    logic [7:0] hi_q, hi_d;
    logic cpu_rst_q, cpu_rst_d, load_done_q, load_done_d, load_err_q, load_err_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic mem_we, xfer, in_range;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
`ifdef CPU_BOOT_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;
`endif

    // rst gating keeps a byte offered during reset from looking accepted
    assign rx_ready = !rst && state_q != RUN && state_q != ERR;
    assign xfer = rx_valid && rx_ready;
    assign in_range = int'(idx_q) < DEPTH;
    assign cpu_rst = cpu_rst_q;
    assign load_done = load_done_q;
    assign load_err = load_err_q;
    assign cpu_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        len_d = len_q;
        hi_d = hi_q;
        idx_d = idx_q;
        load_err_d = load_err_q;
        mem_we = 1'b0;
        mem_waddr = cpu_addr;
        mem_wdata = cpu_wdata;
`ifdef CPU_BOOT_CHECKSUM_EN
        chk_d = chk_q;
`endif
        if (state_q == RUN) begin
            mem_we = cpu_we && !rst;
        end else if (xfer) begin
`ifdef CPU_BOOT_CHECKSUM_EN
            if (state_q == DAT_HI || state_q == DAT_LO) chk_d = chk_q ^ rx_data;
`endif
            case (state_q)
                HDR_HI: begin
                    len_d[15:8] = rx_data;
                    state_d = HDR_LO;
                end
                HDR_LO: begin
                    len_d[7:0] = rx_data;
                    state_d = {len_q[15:8], rx_data} == 16'd0 ? DONE : DAT_HI;
                end
                DAT_HI: begin
                    hi_d = rx_data;
                    state_d = DAT_LO;
                end
                DAT_LO: begin
                    // words past the end of memory are dropped, the load still completes
                    mem_we = in_range;
                    mem_waddr = idx_q[ADDR_W-1:0];
                    mem_wdata = {hi_q, rx_data};
                    load_err_d = load_err_q || !in_range;
                    idx_d = idx_q + 16'd1;
                    state_d = idx_d == len_q ? DONE : DAT_HI;
                end
`ifdef CPU_BOOT_CHECKSUM_EN
                CHK: begin
                    state_d = rx_data == chk_q ? RUN : ERR;
                    load_err_d = load_err_q || rx_data != chk_q;
                end
`endif
                default: ;
            endcase
        end
        cpu_rst_d = state_d != RUN;
        load_done_d = state_d == RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HDR_HI;
            len_q <= '0;
            idx_q <= '0;
            hi_q <= '0;
            cpu_rst_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            idx_q <= idx_d;
            hi_q <= hi_d;
            cpu_rst_q <= cpu_rst_d;
            load_done_q <= load_done_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef CPU_BOOT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) chk_q <= '0;
        else chk_q <= chk_d;
    end
`endif

    // read-first: the registered read sees the word before this edge's write
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rdata_q <= (rst || state_q != RUN) ? '0 : mem[cpu_addr];
    end
endmodule

// File: tb/tb_cpu_boot_mem.sv
// tb_cpu_boot_mem: scoreboard bench for the cpu_boot_mem loader and run-mode bus.
module tb_cpu_boot_mem;
    logic clk = 0, rst = 1, rx_valid = 0, cpu_we = 0;
    logic [7:0] rx_data = 0;
    logic [12:0] cpu_addr = 0;
    logic [15:0] cpu_wdata = 0;
    logic rx_ready, cpu_rst, load_done, load_err;
    logic [15:0] cpu_rdata;
    int checks = 0, errors = 0, acc_cnt = 0;
    logic st_req = 0, rd_req = 0, rd_vld = 0;
    typedef struct { string name; logic [15:0] exp; } exp_t;
    exp_t st_q[$], rd_q[$];
    logic [7:0] img[$];
`ifdef CPU_BOOT_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    cpu_boot_mem dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .cpu_rst(cpu_rst), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_vld <= rd_req;
        if (rx_valid && rx_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: status compared while st_req is high, read data one cycle after rd_req
    always @(negedge clk) begin
        exp_t e;
        if (st_req) begin
            if (st_q.size() == 0) cmp("st_underflow", 16'd1, 16'd0);
            else begin
                e = st_q.pop_front();
                cmp(e.name, {12'd0, rx_ready, cpu_rst, load_done, load_err}, e.exp);
            end
        end
        if (rd_vld) begin
            if (rd_q.size() == 0) cmp("rd_underflow", 16'd1, 16'd0);
            else begin
                e = rd_q.pop_front();
                cmp(e.name, cpu_rdata, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp = {rx_ready, cpu_rst, load_done, load_err}
    task automatic status(string name, logic [3:0] exp);
        st_q.push_back('{name, {12'd0, exp}});
        st_req = 1;
        tick();
        st_req = 0;
    endtask

    task automatic bus(logic we, logic [12:0] a, logic [15:0] d, string name, logic [15:0] exp);
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        if (name != "") begin
            rd_q.push_back('{name, exp});
            rd_req = 1;
        end
        tick();
        cpu_we = 0;
        rd_req = 0;
    endtask

    task automatic send_byte(logic [7:0] b, int gap);
        bit r;
        int n = 0;
        repeat (gap) tick();
        rx_valid = 1;
        rx_data = b;
        do begin
            @(negedge clk);
            r = rx_ready;
            tick();
            n++;
        end while (!r && n < 100);
        rx_valid = 0;
        if (!r) cmp("rx_timeout", 16'd0, 16'd1);
    endtask

    task automatic send_img(int mode, bit raw);
`ifdef CPU_BOOT_CHECKSUM_EN
        logic [7:0] cs = 0;
`endif
        for (int i = 0; i < img.size(); i++) begin
`ifdef CPU_BOOT_CHECKSUM_EN
            if (i >= 2) cs ^= img[i];
`endif
            send_byte(img[i], mode == 0 ? 0 : (i % 2 == 1 ? 1 : int'($urandom_range(0, 10))));
        end
`ifdef CPU_BOOT_CHECKSUM_EN
        if (!raw) send_byte(cs, 0);
`else
        if (!raw) rx_valid = 0;
`endif
    endtask

    task automatic do_rst();
        int a = acc_cnt;
        rst = 1;
        rx_valid = 1;
        rx_data = 8'h55;
        tick();
        tick();
        status("rst_hold", 4'b0100);
        rst = 0;
        rx_valid = 0;
        cmp("rst_blocks_rx", 16'(acc_cnt - a), 16'd0);
        status("after_rst", 4'b1100);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int a0;
        logic [15:0] w;
        do_rst();
        bus(0, 13'd0, 16'd0, "rdata_idle", 16'h0000);
        // basic two-word image, cpu_rst timing
        img = {8'h00, 8'h02, 8'hA0, 8'h05, 8'hE0, 8'h00};
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) send_byte(img[i], 0);
        status("before_last", 4'b1100);
        send_byte(img[5], 0);
`ifdef CPU_BOOT_CHECKSUM_EN
        status("in_chk", 4'b1100);
        send_byte(8'h45, 0);
`endif
        status("run_entered", 4'b0010);
        cmp("acc_cnt", 16'(acc_cnt - a0), 16'(6 + CS));
        bus(0, 13'd1, 16'd0, "rd1", 16'hE000);
        bus(0, 13'd0, 16'd0, "rd0", 16'hA005);
        bus(1, 13'd5, 16'h1111, "", 16'd0);
        bus(1, 13'd5, 16'h1234, "rdw_old", 16'h1111);
        bus(0, 13'd5, 16'd0, "rd5", 16'h1234);
        a0 = acc_cnt;
        rx_valid = 1;
        rx_data = 8'h77;
        repeat (3) tick();
        rx_valid = 0;
        cmp("run_no_rx", 16'(acc_cnt - a0), 16'd0);
        status("run_hold", 4'b0010);
        bus(1, 13'd0, 16'd0, "", 16'd0);
        bus(1, 13'd1, 16'd0, "", 16'd0);
        // same image with gaps and a toggling valid
        do_rst();
        a0 = acc_cnt;
        send_img(1, 0);
        cmp("gap_acc", 16'(acc_cnt - a0), 16'(6 + CS));
        status("gap_run", 4'b0010);
        bus(0, 13'd0, 16'd0, "gap_rd0", 16'hA005);
        bus(0, 13'd1, 16'd0, "gap_rd1", 16'hE000);
        // zero-length image
        do_rst();
        img = {8'h00, 8'h00};
        send_img(0, 0);
        status("len0_run", 4'b0010);
        bus(0, 13'd0, 16'd0, "len0_nowrite", 16'hA005);
`ifdef CPU_BOOT_CHECKSUM_EN
        do_rst();
        img = {8'h00, 8'h00, 8'h01};
        send_img(0, 1);
        status("len0_bad_cs", 4'b0101);
        do_rst();
        img = {8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        send_img(0, 1);
        status("cs_ok", 4'b0010);
        bus(0, 13'd0, 16'd0, "cs_rd0", 16'h1234);
        do_rst();
        img = {8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        send_img(0, 1);
        status("cs_bad", 4'b0101);
`endif
        // overflow: one word more than memory depth
        do_rst();
        img = {8'h20, 8'h01};
        for (int i = 0; i <= 8192; i++) begin
            w = i == 8192 ? 16'hFFFF : 16'(i) ^ 16'h5A5A;
            img.push_back(w[15:8]);
            img.push_back(w[7:0]);
        end
        send_img(0, 0);
        status("ovf_run", 4'b0011);
        bus(0, 13'd0, 16'd0, "ovf_rd0", 16'h5A5A);
        bus(0, 13'd2, 16'd0, "ovf_rd2", 16'h5A58);
        bus(0, 13'd8191, 16'd0, "ovf_rd_last", 16'h45A5);
        // reset in the middle of a load
        do_rst();
        img = {8'h00, 8'h03, 8'hBE, 8'hEF, 8'h12};
        send_img(0, 1);
        status("mid_load", 4'b1100);
        do_rst();
        img = {8'h00, 8'h01, 8'hCA, 8'hFE};
        send_img(0, 0);
        status("reload_run", 4'b0010);
        bus(0, 13'd0, 16'd0, "reload_rd0", 16'hCAFE);
        bus(0, 13'd1, 16'd0, "reload_rd1", 16'h5A5B);
        tick();
        tick();
        cmp("sb_drain", 16'(rd_q.size() + st_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
